// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator: valid/ready command in, valid/ready response out.
// Optional bus watchdog: define WB_CMD_MASTER_TIMEOUT_EN to abort a silent slave after TIMEOUT_CYCLES.
module wb_cmd_master #(
  parameter int Dw             = 32,
  parameter int Aw             = 32,
  parameter int SELw           = 4,
  parameter int TAGw           = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic            clk,
  input  logic            reset,
  // Handshakes: a beat transfers on a rising edge where valid && ready; the sender
  // holds valid and payload stable until that edge, and ready never depends on valid.
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [Aw-1:0]   cmd_addr,
  input  logic [Dw-1:0]   cmd_dat,
  input  logic [SELw-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [Dw-1:0]   rsp_dat,
  output logic [1:0]      rsp_status,
  output logic [Dw-1:0]   m_dat_o,
  output logic [SELw-1:0] m_sel_o,
  output logic [Aw-1:0]   m_addr_o,
  output logic [TAGw-1:0] m_tag_o,
  output logic            m_we_o,
  output logic            m_stb_o,
  output logic            m_cyc_o,
  input  logic [Dw-1:0]   m_dat_i,
  input  logic            m_ack_i,
  input  logic            m_err_i,
  input  logic            m_rty_i
);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b11;
  localparam int         RW     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

  state_t          state;
  logic [RW-1:0]   retry_cnt;
  logic            bus_done;
  logic            bus_retry;
  logic [1:0]      bus_status;
  logic [Dw-1:0]   bus_dat;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam int         TW_RAW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int         TW       = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]   tmo_cnt;
`endif

  assign cmd_ready = (state == IDLE) && !reset;
  assign m_tag_o   = '0;

  // Termination decode, only acted on in BUS. Priority err > ack > rty > timeout.
  always_comb begin
    bus_done   = 1'b0;
    bus_retry  = 1'b0;
    bus_status = ST_OK;
    bus_dat    = '0;
    if (m_err_i) begin
      bus_done   = 1'b1;
      bus_status = ST_ERR;
    end else if (m_ack_i) begin
      bus_done   = 1'b1;
      bus_dat    = m_we_o ? '0 : m_dat_i;
    end else if (m_rty_i) begin
      if (retry_cnt == RW'(MAX_RETRY)) begin
        bus_done   = 1'b1;
        bus_status = ST_RTY;
      end else begin
        bus_retry  = 1'b1;
      end
    end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    else if (tmo_cnt == TMO_LAST) begin
      bus_done   = 1'b1;
      bus_status = ST_TMO;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      retry_cnt  <= '0;
      m_stb_o    <= 1'b0;
      m_cyc_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_addr_o   <= '0;
      m_dat_o    <= '0;
      m_sel_o    <= '0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= ST_OK;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            m_we_o    <= cmd_we;
            m_addr_o  <= cmd_addr;
            m_dat_o   <= cmd_dat;
            m_sel_o   <= cmd_sel;
            m_stb_o   <= 1'b1;
            m_cyc_o   <= 1'b1;
            retry_cnt <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            state     <= BUS;
          end
        end
        BUS: begin
          if (bus_done) begin
            m_stb_o    <= 1'b0;
            m_cyc_o    <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_status <= bus_status;
            rsp_dat    <= bus_dat;
            state      <= RESP;
          end else if (bus_retry) begin
            m_stb_o    <= 1'b0;
            m_cyc_o    <= 1'b0;
            retry_cnt  <= retry_cnt + RW'(1);
            state      <= GAP;
          end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          else begin
            tmo_cnt    <= tmo_cnt + TW'(1);
          end
`endif
        end
        GAP: begin
          // Request fields stay latched; only the strobes re-assert.
          m_stb_o <= 1'b1;
          m_cyc_o <= 1'b1;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state   <= BUS;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: GPIO-style slave model, directed and random transactions,
// expected responses derived from retry/termination rules and cycle arithmetic.
module tb_wb_cmd_master;
  localparam int Dw = 32;
  localparam int Aw = 32;
  localparam int SELw = 4;
  localparam int TAGw = 3;
  localparam int MAX_RETRY = 3;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif
  localparam int TERM_ACK = 0;
  localparam int TERM_ERR = 1;
  localparam int TERM_BOTH = 2;
  localparam int TERM_NONE = 3;

  logic            clk, reset;
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [Aw-1:0]   cmd_addr;
  logic [Dw-1:0]   cmd_dat;
  logic [SELw-1:0] cmd_sel;
  logic            rsp_valid, rsp_ready;
  logic [Dw-1:0]   rsp_dat;
  logic [1:0]      rsp_status;
  logic [Dw-1:0]   m_dat_o, m_dat_i;
  logic [SELw-1:0] m_sel_o;
  logic [Aw-1:0]   m_addr_o;
  logic [TAGw-1:0] m_tag_o;
  logic            m_we_o, m_stb_o, m_cyc_o, m_ack_i, m_err_i, m_rty_i;

  int n_tests = 0;
  int n_fail = 0;
  logic [Dw+1:0] exp_q[$];
  logic [Dw-1:0] exp_mem[16];

  int            slv_rty_n, slv_term, slv_delay, slv_phase, slv_wcnt;
  logic [Dw-1:0] slv_rdata;
  logic          slv_stray;
  logic [Dw-1:0] slv_mem[16];
  int            stb_phases, stb_cycles;
  logic          stb_prev;

  wb_cmd_master #(.Dw(Dw), .Aw(Aw), .SELw(SELw), .TAGw(TAGw),
                  .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_addr_o(m_addr_o), .m_tag_o(m_tag_o),
    .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- slave model: registered reply after slv_delay+1 stb edges ----------------
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ack_i <= 1'b0; m_err_i <= 1'b0; m_rty_i <= 1'b0; m_dat_i <= '0;
      slv_phase <= 0; slv_wcnt <= 0;
      for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
    end else begin
      m_ack_i <= 1'b0; m_err_i <= 1'b0; m_rty_i <= 1'b0; m_dat_i <= 32'hDEAD_BEEF;
      if (cmd_ready) slv_phase <= 0;
      if (!m_stb_o) slv_wcnt <= 0;
      else if (m_cyc_o && !(m_ack_i || m_err_i || m_rty_i)) begin
        if (slv_wcnt < slv_delay) slv_wcnt <= slv_wcnt + 1;
        else begin
          slv_wcnt <= 0;
          if (slv_phase < slv_rty_n) begin
            m_rty_i <= 1'b1; slv_phase <= slv_phase + 1;
          end else if (slv_term == TERM_ACK) begin
            m_ack_i <= 1'b1; m_dat_i <= slv_rdata;
            if (m_we_o) slv_mem[m_addr_o[3:0]] <= m_dat_o;
          end else if (slv_term == TERM_ERR) begin
            m_err_i <= 1'b1;
          end else if (slv_term == TERM_BOTH) begin
            m_err_i <= 1'b1; m_ack_i <= 1'b1; m_dat_i <= slv_rdata;
          end
        end
      end
      if (slv_stray) begin
        m_ack_i <= 1'b1; m_err_i <= 1'b1; m_rty_i <= 1'b1; m_dat_i <= slv_rdata;
      end
    end
  end

  // ---------------- strobe monitor ----------------
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      stb_phases <= 0; stb_cycles <= 0; stb_prev <= 1'b0;
    end else begin
      if (m_stb_o && !stb_prev) stb_phases <= stb_phases + 1;
      if (m_stb_o) stb_cycles <= stb_cycles + 1;
      stb_prev <= m_stb_o;
    end
  end

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one full command/response transaction ----------------
  task automatic run_txn(input logic we, input logic [Aw-1:0] addr, input logic [Dw-1:0] dat,
                         input logic [SELw-1:0] sel, input int rty_n, input int term,
                         input int delay, input logic [Dw-1:0] rdata, input int hold);
    int phases, lat, k, p0, c0;
    logic [1:0] st;
    logic [Dw-1:0] edat;
    logic [Dw+1:0] exp;
    bit exhausted;
    exhausted = rty_n > MAX_RETRY;
    phases = exhausted ? MAX_RETRY + 1 : rty_n + 1;
    if (exhausted) begin
      st = 2'b11; lat = phases * (delay + 3);
    end else if (term == TERM_NONE) begin
      st = 2'b10; lat = rty_n * (delay + 3) + TMO + 1;
    end else begin
      st = (term == TERM_ACK) ? 2'b00 : 2'b01; lat = phases * (delay + 3);
    end
    edat = (st == 2'b00 && !we) ? rdata : '0;
    exp_q.push_back({st, edat});
    if (we && st == 2'b00) exp_mem[addr[3:0]] = dat;

    slv_rty_n = rty_n; slv_term = term; slv_delay = delay; slv_rdata = rdata;
    @(negedge clk);
    cmd_we = we; cmd_addr = addr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    p0 = stb_phases; c0 = stb_cycles;
    #1 cmd_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk); k++;
      if (k == 1) begin
        check("bus_ctl", {m_stb_o, m_cyc_o, m_we_o, m_sel_o, m_tag_o}, {2'b11, we, sel, 3'b000});
        check("bus_addr", m_addr_o, addr);
        check("bus_dat", m_dat_o, dat);
      end
    end while (!rsp_valid && k < lat + 400);
    check("latency", k, lat);
    check("stb_phases", stb_phases - p0, phases);
    if (term == TERM_NONE && !exhausted)
      check("stb_cycles", stb_cycles - c0, rty_n * (delay + 2) + TMO);
    exp = exp_q.pop_front();
    check("rsp", {rsp_valid, rsp_status, rsp_dat}, {1'b1, exp});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold", {rsp_valid, rsp_status, rsp_dat}, {1'b1, exp});
      check("cmd_ready_hold", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_done_ready", {rsp_valid, cmd_ready}, 2'b01);
    check("slave_mem", slv_mem[addr[3:0]], exp_mem[addr[3:0]]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; slv_rty_n = 0; slv_term = TERM_ACK; slv_delay = 0; slv_rdata = '0;
    slv_stray = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_ctl", {m_stb_o, m_cyc_o, m_we_o, rsp_valid, cmd_ready}, 5'b0);
    check("rst_bus", {m_dat_o, m_addr_o, m_sel_o, m_tag_o}, 0);
    check("rst_rsp", {rsp_dat, rsp_status}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1);

    run_txn(1'b1, 1, 32'h5, 4'hF, 0, TERM_ACK, 0, 32'h0, 0);
    run_txn(1'b0, 2, $urandom, 4'hF, 0, TERM_ACK, 0, 32'hA5, 0);
    run_txn(1'b0, 3, $urandom, 4'hF, 2, TERM_ACK, 0, $urandom, 0);
    run_txn(1'b1, 4, $urandom, 4'hF, 4, TERM_ACK, 0, $urandom, 0);
    run_txn(1'b0, 5, $urandom, 4'h3, 0, TERM_BOTH, 0, $urandom, 0);
    run_txn(1'b0, 6, $urandom, 4'hC, 0, TERM_ERR, 1, $urandom, 0);
    run_txn(1'b0, 7, $urandom, 4'hF, 0, TERM_ACK, 2, $urandom, 5);

    // Stray terminations while idle must not produce a response.
    @(negedge clk);
    slv_stray = 1'b1; slv_rdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_idle", {rsp_valid, m_stb_o}, 2'b00);
    end
    slv_stray = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_cmd_ready", cmd_ready, 1);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    run_txn(1'b0, 8, $urandom, 4'hF, 0, TERM_NONE, 0, $urandom, 0);
    run_txn(1'b0, 9, $urandom, 4'hF, 0, TERM_ACK, TMO - 2, $urandom, 0);
    run_txn(1'b1, 10, $urandom, 4'hF, 1, TERM_NONE, 1, $urandom, 0);
`endif

    for (int n = 0; n < 30; n++) begin
      run_txn(1'($urandom_range(0, 1)), Aw'($urandom_range(0, 15)), $urandom,
              SELw'($urandom_range(0, 15)), $urandom_range(0, 5), $urandom_range(0, 2),
              $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
    end

    // Reset in the middle of a bus cycle: strobes drop at once, no response follows.
    slv_rty_n = 0; slv_term = TERM_NONE; slv_delay = 0;
    @(negedge clk);
    cmd_we = 1'b1; cmd_addr = 12; cmd_dat = $urandom; cmd_sel = 4'hF; cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_bus_stb", {m_stb_o, m_cyc_o}, 2'b11);
    #2 reset = 1'b1;
    #1 check("async_rst_drop", {m_stb_o, m_cyc_o, rsp_valid, cmd_ready}, 4'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {rsp_valid, m_stb_o}, 2'b00);
    end
    check("post_rst_ready", cmd_ready, 1);
    run_txn(1'b0, 13, $urandom, 4'hF, 1, TERM_ACK, 0, $urandom, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
